// File: rtl/ncl_dr_sync_rx.sv
// Dual-rail NCL to synchronous receiver: per-rail synchronisers, DATA/NULL completion
// detection, the ko handshake back to the gate network and a one-word valid/ready buffer.
module ncl_dr_sync_rx #(
    parameter int W    = 4,
    parameter int SYNC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_t,
    input  logic [W-1:0] d_f,
    output logic         ko,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err
);

    // Output handshake: a word transfers on any rising edge where
    // out_valid && out_ready; out_data is stable while out_valid is high.

    typedef enum logic {
        WAIT_NULL = 1'b0,
        WAIT_DATA = 1'b1
    } state_t;

    logic [W-1:0] sync_t_q [SYNC];
    logic [W-1:0] sync_f_q [SYNC];
    logic [W-1:0] st;
    logic [W-1:0] sf;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC; s++) begin
                sync_t_q[s] <= '0;
                sync_f_q[s] <= '0;
            end
        end else begin
            sync_t_q[0] <= d_t;
            sync_f_q[0] <= d_f;
            for (int s = 1; s < SYNC; s++) begin
                sync_t_q[s] <= sync_t_q[s-1];
                sync_f_q[s] <= sync_f_q[s-1];
            end
        end
    end

    assign st = sync_t_q[SYNC-1];
    assign sf = sync_f_q[SYNC-1];

    // Rails are monotonic within a wavefront, so a partially synchronised word can
    // only look incomplete, never falsely complete.
    logic cdata;
    logic cnull;
    logic ill;
    logic load;

    assign cdata = &(st ^ sf);
    assign cnull = ~|(st | sf);
    assign ill   = |(st & sf);

    state_t       state_q;
    logic         ko_q;
    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic         err_q;

    assign load = (state_q == WAIT_DATA) && cdata && (!out_valid_q || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_NULL;
            ko_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (ill) begin
                err_q <= 1'b1;
            end

            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= st;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                WAIT_NULL: begin
                    if (cnull) begin
                        state_q <= WAIT_DATA;
                        ko_q    <= 1'b1;
                    end
                end
                WAIT_DATA: begin
                    // A complete word waits here with ko high until the buffer frees up.
                    if (load) begin
                        state_q <= WAIT_NULL;
                        ko_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= WAIT_NULL;
                    ko_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ko        = ko_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ncl_dr_sync_rx.sv
// Directed bench for ncl_dr_sync_rx: reset, full and skewed wavefronts, back-pressure,
// illegal codewords and mid-operation reset, with hand-computed expectations.
module tb_ncl_dr_sync_rx;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] d_t;
    logic [W-1:0] d_f;
    logic         ko;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         err;

    int checks   = 0;
    int failures = 0;

    ncl_dr_sync_rx #(.W(W), .SYNC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_t       (d_t),
        .d_f       (d_f),
        .ko        (ko),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: inputs change and outputs are sampled 1ns after a rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] t, input logic [W-1:0] f);
        d_t = t;
        d_f = f;
    endtask

    // scoreboard comparison
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(4'h0, 4'h0);
        step(2);
        check("rst_ko", 32'(ko), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        step(1);
        check("post_rst_ko", 32'(ko), 32'd1);

        // full DATA word A
        drive(4'b1010, 4'b0101);
        step(2);
        check("a_early_valid", 32'(out_valid), 32'd0);
        check("a_early_ko", 32'(ko), 32'd1);
        step(1);
        check("a_valid", 32'(out_valid), 32'd1);
        check("a_data", 32'(out_data), 32'hA);
        check("a_ko", 32'(ko), 32'd0);
        step(1);
        check("a_accept_valid", 32'(out_valid), 32'd0);
        drive(4'h0, 4'h0);
        step(2);
        check("null_early_ko", 32'(ko), 32'd0);
        step(1);
        check("null_ko", 32'(ko), 32'd1);

        // skewed wavefront: one rail per clock, value A
        drive(4'b0000, 4'b0001);
        step(1);
        drive(4'b0010, 4'b0001);
        step(1);
        drive(4'b0010, 4'b0101);
        step(1);
        check("skew_partial_valid", 32'(out_valid), 32'd0);
        drive(4'b1010, 4'b0101);
        step(2);
        check("skew_early_valid", 32'(out_valid), 32'd0);
        step(1);
        check("skew_valid", 32'(out_valid), 32'd1);
        check("skew_data", 32'(out_data), 32'hA);
        drive(4'h0, 4'h0);
        step(3);
        check("skew_null_ko", 32'(ko), 32'd1);
        check("skew_null_valid", 32'(out_valid), 32'd0);

        // back-pressure
        out_ready = 1'b0;
        drive(4'hA, 4'h5);
        step(3);
        check("bp_a_valid", 32'(out_valid), 32'd1);
        check("bp_a_ko", 32'(ko), 32'd0);
        drive(4'h0, 4'h0);
        step(3);
        check("bp_null_ko", 32'(ko), 32'd1);
        check("bp_null_valid", 32'(out_valid), 32'd1);
        drive(4'h5, 4'hA);
        step(5);
        check("bp_stall_ko", 32'(ko), 32'd1);
        check("bp_stall_data", 32'(out_data), 32'hA);
        check("bp_stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step(1);
        check("bp_load_data", 32'(out_data), 32'h5);
        check("bp_load_valid", 32'(out_valid), 32'd1);
        check("bp_load_ko", 32'(ko), 32'd0);
        step(1);
        check("bp_drain_valid", 32'(out_valid), 32'd0);
        check("bp_drain_data", 32'(out_data), 32'h5);
        drive(4'h0, 4'h0);
        step(3);
        check("bp_null2_ko", 32'(ko), 32'd1);

        // illegal codeword on bit 0
        drive(4'b0001, 4'b0001);
        step(3);
        check("ill_err", 32'(err), 32'd1);
        check("ill_valid", 32'(out_valid), 32'd0);
        check("ill_ko", 32'(ko), 32'd1);
        drive(4'h0, 4'h0);
        step(3);
        check("ill_null_err", 32'(err), 32'd1);
        out_ready = 1'b0;
        drive(4'hA, 4'h5);
        step(3);
        check("ill_data_err", 32'(err), 32'd1);
        check("ill_data_valid", 32'(out_valid), 32'd1);
        check("ill_data_data", 32'(out_data), 32'hA);
        check("ill_data_ko", 32'(ko), 32'd0);

        // reset mid-operation
        rst = 1'b1;
        step(1);
        check("mid_rst_ko", 32'(ko), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'h0);
        check("mid_rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        drive(4'h0, 4'h0);
        step(1);
        check("mid_rst_release_ko", 32'(ko), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
